// File: rtl/jt89_pkg.sv
// rtl/jt89_pkg.sv - shared types and constants for the jt89 write queue
package jt89_pkg;

  // Drain FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Default number of clk_en ticks the PSG stays busy after a write
  localparam int WAIT_CEN_DEF = 32;

  // Width of the HOLD counter, wide enough for WAIT_CEN up to 255
  localparam int CNT_W = 8;

endpackage

// File: rtl/jt89_wrq_fifo.sv
// rtl/jt89_wrq_fifo.sv - byte queue with push/pop, full/empty and head output
module jt89_wrq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  // A push is refused while full even if a pop frees a slot this cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage write at the tail; contents need no reset since count gates use
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt89_wrq.sv
// rtl/jt89_wrq.sv - CPU write queue draining into the PSG; JT89_WRQ_READY_EN selects READY-pin style cpu_ready
module jt89_wrq
  import jt89_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WAIT_CEN = WAIT_CEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cpu_we,
  input  logic [7:0] cpu_din,
  output logic       cpu_ready,
  output logic       psg_wr_n,
  output logic [7:0] psg_din,
  output logic       ovf
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             pop;

  // The head leaves the queue on the clk_en cycle that ends the ISSUE phase
  assign pop = (state == ST_ISSUE) && clk_en;

  jt89_wrq_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_we),
    .pop   (pop),
    .din   (cpu_din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Drain FSM: psg_wr_n/psg_din are registered so nothing from the CPU side leaks through
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      psg_wr_n <= 1'b1;
      psg_din  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state    <= ST_ISSUE;
            psg_wr_n <= 1'b0;
            psg_din  <= head;
          end
        end
        ST_ISSUE: begin
          if (clk_en) begin
            psg_wr_n <= 1'b1;
            if (WAIT_CEN == 0) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_HOLD;
              hold_cnt <= CNT_W'(WAIT_CEN);
            end
          end
        end
        ST_HOLD: begin
          if (clk_en) begin
            if (hold_cnt <= CNT_W'(1)) begin
              state    <= ST_IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          psg_wr_n <= 1'b1;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Sticky overflow: any write attempted into a full queue
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (cpu_we && full) begin
      ovf <= 1'b1;
    end
  end

`ifdef JT89_WRQ_READY_EN
  logic pushed_q;

  // Remember an accepted push so READY drops in the very next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pushed_q <= 1'b0;
    end else begin
      pushed_q <= cpu_we && !full;
    end
  end

  assign cpu_ready = empty && (state == ST_IDLE) && !pushed_q;
`else
  assign cpu_ready = !full;
`endif

endmodule

// File: tb/tb_jt89_wrq.sv
// tb/tb_jt89_wrq.sv - directed self-checking bench for jt89_wrq
module tb_jt89_wrq;
  import jt89_pkg::*;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       cpu_we;
  logic [7:0] cpu_din;
  logic       cpu_ready;
  logic       psg_wr_n;
  logic [7:0] psg_din;
  logic       ovf;

  logic       cpu_we0;
  logic [7:0] cpu_din0;
  logic       cpu_ready0;
  logic       psg_wr_n0;
  logic [7:0] psg_din0;
  logic       ovf0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ce_div = 0;

  logic [7:0] got [$];
  int  gap_min;
  int  gap;
  bit  align_ok;
  bit  prev_low;
  bit  prev_ce;

`ifdef JT89_WRQ_READY_EN
  localparam logic READY_AFTER_POP_PUSH = 1'b0;
  localparam logic READY0_BUSY = 1'b0;
`else
  localparam logic READY_AFTER_POP_PUSH = 1'b1;
  localparam logic READY0_BUSY = 1'b1;
`endif

  jt89_wrq #(.DEPTH(4), .WAIT_CEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .cpu_we    (cpu_we),
    .cpu_din   (cpu_din),
    .cpu_ready (cpu_ready),
    .psg_wr_n  (psg_wr_n),
    .psg_din   (psg_din),
    .ovf       (ovf)
  );

  jt89_wrq #(.DEPTH(4), .WAIT_CEN(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .cpu_we    (cpu_we0),
    .cpu_din   (cpu_din0),
    .cpu_ready (cpu_ready0),
    .psg_wr_n  (psg_wr_n0),
    .psg_din   (psg_din0),
    .ovf       (ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ce_div) clk_en = (cyc % 4 == 0);
  endtask

  task automatic push(input logic [7:0] b);
    cpu_we  = 1'b1;
    cpu_din = b;
    tick();
    cpu_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    got.delete();
    gap_min  = 1000000;
    gap      = 0;
    align_ok = 1'b1;
    prev_low = 1'b0;
    prev_ce  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (!psg_wr_n && !prev_low) begin
        got.push_back(psg_din);
        if (got.size() > 1 && gap < gap_min) gap_min = gap;
      end
      if (psg_wr_n && prev_low) begin
        if (!prev_ce) align_ok = 1'b0;
        gap = 0;
      end
      if (psg_wr_n && clk_en) gap++;
      prev_low = !psg_wr_n;
      prev_ce  = clk_en;
      tick();
    end
  endtask

  initial begin
    int  lows;
    bit  hold_ok;
    bit  found;

    rst      = 1'b1;
    clk_en   = 1'b0;
    cpu_we   = 1'b0;
    cpu_din  = 8'h00;
    cpu_we0  = 1'b0;
    cpu_din0 = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_wr_n", psg_wr_n, 1'b1);
    chk("reset_din", psg_din, 8'h00);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_ready", cpu_ready, 1'b1);

    // Single write, clk_en every cycle: pulse at t+2, 32 HOLD cycles, IDLE
    clk_en = 1'b1;
    push(8'h9F);
    chk("t1_wr_n_high", psg_wr_n, 1'b1);
    tick();
    chk("t2_wr_n_low", psg_wr_n, 1'b0);
    chk("t2_din", psg_din, 8'h9F);
    hold_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (dut.state != ST_HOLD || psg_wr_n != 1'b1) hold_ok = 1'b0;
    end
    chk("hold_32_cycles", hold_ok, 1'b1);
    tick();
    chk("idle_after_hold", dut.state, ST_IDLE);

    // Two back-to-back writes with clk_en one-in-four
    ce_div = 1'b1;
    push(8'h80);
    push(8'h0A);
    collect(400);
    chk("div4_pulses", got.size(), 2);
    if (got.size() == 2) begin
      chk("div4_first", got[0], 8'h80);
      chk("div4_second", got[1], 8'h0A);
    end
    chk("div4_align", align_ok, 1'b1);
    chk("div4_gap_ge32", (gap_min >= 32), 1'b1);

    // Overflow with clk_en stalled, then drain exactly four
    ce_div = 1'b0;
    clk_en = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("full_ovf_clear", ovf, 1'b0);
    chk("full_ready", cpu_ready, 1'b0);
    chk("stall_wr_n", psg_wr_n, 1'b0);
    chk("stall_din", psg_din, 8'h11);
    push(8'h55);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_ready", cpu_ready, 1'b0);
    clk_en = 1'b1;
    collect(300);
    chk("drain_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("drain_0", got[0], 8'h11);
      chk("drain_1", got[1], 8'h22);
      chk("drain_2", got[2], 8'h33);
      chk("drain_3", got[3], 8'h44);
    end
    chk("ovf_sticky", ovf, 1'b1);

    // Push into a full queue in the same cycle as a pop
    do_reset();
    chk("rst_clears_ovf", ovf, 1'b0);
    clk_en = 1'b0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    chk("pp_issue_wr_n", psg_wr_n, 1'b0);
    clk_en  = 1'b1;
    cpu_we  = 1'b1;
    cpu_din = 8'hA5;
    tick();
    cpu_we = 1'b0;
    chk("pp_ovf", ovf, 1'b1);
    chk("pp_count", dut.u_fifo.count, 3);
    chk("pp_ready", cpu_ready, READY_AFTER_POP_PUSH);
    collect(200);
    chk("pp_rest_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("pp_rest_0", got[0], 8'hA2);
      chk("pp_rest_1", got[1], 8'hA3);
      chk("pp_rest_2", got[2], 8'hA4);
    end

    // Reset in the middle of HOLD with two bytes still queued
    do_reset();
    clk_en = 1'b1;
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (dut.state == ST_HOLD && dut.hold_cnt == 8'd10) found = 1'b1;
      else tick();
    end
    chk("hold10_reached", found, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_wr_n", psg_wr_n, 1'b1);
    chk("abort_din", psg_din, 8'h00);
    chk("abort_ovf", ovf, 1'b0);
    chk("abort_ready", cpu_ready, 1'b1);
    rst  = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!psg_wr_n) lows++;
    end
    chk("abort_no_pulse", lows, 0);

    // WAIT_CEN=0 instance: single push, back to IDLE right after the pop
    cpu_we0  = 1'b1;
    cpu_din0 = 8'h5A;
    tick();
    cpu_we0 = 1'b0;
    chk("w0_t1_wr_n", psg_wr_n0, 1'b1);
    chk("w0_t1_ready", cpu_ready0, READY0_BUSY);
    tick();
    chk("w0_t2_wr_n", psg_wr_n0, 1'b0);
    chk("w0_t2_din", psg_din0, 8'h5A);
    chk("w0_t2_ready", cpu_ready0, READY0_BUSY);
    tick();
    chk("w0_t3_wr_n", psg_wr_n0, 1'b1);
    chk("w0_t3_ready", cpu_ready0, 1'b1);
    chk("w0_t3_din_held", psg_din0, 8'h5A);
    chk("w0_ovf", ovf0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt89_wrq.md
JT89_WRQ -- requirements
Module: jt89_wrq

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning write-queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter WAIT_CEN, default 32, meaning clk_en ticks the PSG is held busy after each issued write (0..255).
REQ-003 The module SHALL have port clk, input, 1, system clock.
REQ-004 The module SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The module SHALL have port clk_en, input, 1, PSG clock enable, identical to the PSG core's clk_en.
REQ-006 The module SHALL have port cpu_we, input, 1, one-cycle CPU write strobe.
REQ-007 The module SHALL have port cpu_din, input, 8, CPU write byte.
REQ-008 The module SHALL have port cpu_ready, output, 1, CPU may write this cycle.
REQ-009 The module SHALL have port psg_wr_n, output, 1, active-low write to the PSG core.
REQ-010 The module SHALL have port psg_din, output, 8, byte presented to the PSG core.
REQ-011 The module SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-012 Push: cpu_we=1 with queue not full SHALL store cpu_din at tail; cpu_we=1 with queue full SHALL discard the byte and set ovf.
REQ-013 A push when full SHALL be rejected even if a pop occurs in the same cycle; a push and a pop in the same cycle when not full SHALL both succeed, count unchanged.
REQ-014 Drain FSM states SHALL be IDLE, ISSUE, HOLD.
REQ-015 IDLE -> ISSUE on the cycle after the queue is non-empty; a byte pushed in cycle t SHALL drive psg_wr_n low from cycle t+2.
REQ-016 In ISSUE, psg_wr_n SHALL be 0 and psg_din SHALL equal the head entry, held until the first cycle with clk_en=1.
REQ-017 On that clk_en cycle the head SHALL be popped; next state HOLD with counter loaded to WAIT_CEN, or IDLE if WAIT_CEN=0.
REQ-018 In HOLD, the counter SHALL decrement on each clk_en; on the clk_en that takes it to 0 the FSM SHALL return to IDLE.
REQ-019 Outside ISSUE, psg_wr_n SHALL be 1 and psg_din SHALL hold its last value.
REQ-020 Exactly one PSG write SHALL be issued per queued byte, in push order, with no bytes lost or duplicated.
REQ-021 psg_wr_n and psg_din SHALL be decoded from registers only, with no combinational path from cpu_we/cpu_din.
REQ-022 ovf SHALL stay set until reset.
REQ-023 Pointer and counter arithmetic SHALL wrap modulo DEPTH; an occupancy count of width clog2(DEPTH)+1 SHALL distinguish full from empty.

Reset
REQ-024 On rst: queue empty, FSM IDLE, HOLD counter 0, psg_wr_n=1, psg_din=8'h00, ovf=0, cpu_ready=1.
REQ-025 rst asserted mid-ISSUE or mid-HOLD SHALL abort the transfer and discard all queued bytes, with no further psg_wr_n pulse.
REQ-026 rst SHALL take priority over cpu_we and clk_en.

Configuration
REQ-027 With JT89_WRQ_READY_EN defined, cpu_ready SHALL model the chip READY pin: 0 while queue non-empty or FSM not IDLE, and 0 in the cycle after an accepted push.
REQ-028 Without JT89_WRQ_READY_EN, cpu_ready SHALL equal "queue not full".

Structure
REQ-029 Package jt89_pkg SHALL hold the FSM state enum, the WAIT_CEN default constant and the HOLD counter width constant.
REQ-030 Queue storage and pointers SHALL be a sub-module jt89_wrq_fifo (push/pop/full/empty/head); the FSM, counter and ovf SHALL live in jt89_wrq.

Verification
REQ-031 clk_en=1 every cycle, push 8'h9F at t -> psg_wr_n=0 with psg_din=8'h9F exactly in cycle t+2, then 32 cycles of HOLD, then IDLE.
REQ-032 clk_en one-in-4, push 8'h80 then 8'h0A back-to-back -> two psg_wr_n pulses, each coinciding with a clk_en cycle, separated by at least 32 clk_en ticks, in order 80, 0A.
REQ-033 DEPTH=4, clk_en=0, push 5 bytes -> first 4 queued, 5th dropped, ovf=1, cpu_ready=0 (macro off); enable clk_en -> exactly 4 writes.
REQ-034 Queue full, push coinciding with pop -> push rejected, ovf=1, count=3 after the cycle.
REQ-035 rst asserted at HOLD count 10 with 2 bytes queued -> all outputs at reset values next cycle, no psg_wr_n pulse afterwards.
REQ-036 JT89_WRQ_READY_EN defined, WAIT_CEN=0, single push -> cpu_ready=0 from the cycle after the push until the cycle after the pop, then 1.
